// File: rtl/dma_pkg.sv
// Shared types for the DMA channel-priority front end.
// Channel vectors, command fields and the hold handshake states.
package dma_pkg;

  localparam int NUM_CH      = 4;
  localparam int CH_W        = 2;
  localparam int SYNC_STAGES = 2;

  typedef logic [NUM_CH-1:0] ch_vec_t;
  typedef logic [CH_W-1:0]   ch_idx_t;

  typedef struct packed {
    logic    set;
    ch_idx_t ch;
  } ch_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    HREQ,
    HELD
  } hold_state_t;

endpackage

// File: rtl/dma_dreq_sync.sv
// Multi-stage synchroniser for the raw DREQ pins.
// A clear input empties the whole chain in one clock.
module dma_dreq_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    if (clr) sync_d = '0;
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/dma_request_conditioner.sv
// DREQ conditioning, mask/soft-request registers and HRQ/HLDA handshake.
// Define DMA_SW_REQUEST_EN to build the software request register.
module dma_request_conditioner
  import dma_pkg::*;
#(
  parameter int SYNC_STAGES = dma_pkg::SYNC_STAGES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreq_sense_low,
  input  logic              ctrl_disable,
  input  logic              master_clear,
  input  logic              mask_single_we,
  input  logic [2:0]        mask_single_d,
  input  logic              mask_all_we,
  input  logic [NUM_CH-1:0] mask_all_d,
  input  logic              clr_mask_all,
  input  logic              sw_req_we,
  input  logic [2:0]        sw_req_d,
  input  logic [NUM_CH-1:0] autoinit,
  input  logic              tc_pulse,
  input  logic [CH_W-1:0]   tc_chan,
  input  logic              svc_done,
  input  logic              HLDA,
  output logic              HRQ,
  output logic [NUM_CH-1:0] req_eff,
  output logic [NUM_CH-1:0] mask_q,
  output logic [NUM_CH-1:0] req_status
);

  logic        clr;
  ch_vec_t     dreq_sync;
  ch_vec_t     dreq_s;
  ch_vec_t     sw_pend;
  ch_vec_t     mask_d;
  ch_vec_t     req_eff_q, req_eff_d;
  logic        hrq_q, hrq_d;
  hold_state_t state_q, state_d;
  ch_cmd_t     single_cmd;

  assign clr        = RESET | master_clear;
  assign single_cmd = ch_cmd_t'(mask_single_d);

  dma_dreq_sync #(
    .WIDTH  (NUM_CH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .clr  (clr),
    .din  (DREQ),
    .dout (dreq_sync)
  );

  assign dreq_s     = dreq_sync ^ {NUM_CH{dreq_sense_low}};
  assign req_status = dreq_s | sw_pend;

`ifdef DMA_SW_REQUEST_EN
  ch_vec_t sw_pend_q, sw_pend_d;
  ch_cmd_t sw_cmd;

  assign sw_cmd = ch_cmd_t'(sw_req_d);

  always_comb begin
    sw_pend_d = sw_pend_q;
    if (tc_pulse) sw_pend_d[tc_chan] = 1'b0;
    if (sw_req_we) sw_pend_d[sw_cmd.ch] = sw_cmd.set;
    if (clr) sw_pend_d = '0;
  end

  always_ff @(posedge CLK) begin
    sw_pend_q <= sw_pend_d;
  end

  assign sw_pend = sw_pend_q;
`else
  logic unused_sw;
  assign unused_sw = ^{sw_req_we, sw_req_d};
  assign sw_pend   = '0;
`endif

  // Later assignments win: write order encodes bit priority
  always_comb begin
    mask_d = mask_q;
    if (tc_pulse && !autoinit[tc_chan]) mask_d[tc_chan] = 1'b1;
    if (mask_single_we) mask_d[single_cmd.ch] = single_cmd.set;
    if (clr_mask_all) mask_d = '0;
    if (mask_all_we) mask_d = mask_all_d;
    if (clr) mask_d = '1;
  end

  always_comb begin
    req_eff_d = ctrl_disable ? '0 : (dreq_s | sw_pend) & ~mask_q;
    if (clr) req_eff_d = '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|req_eff_q) state_d = HREQ;
      HREQ: begin
        if (HLDA) state_d = HELD;
        else if (req_eff_q == '0) state_d = IDLE;
      end
      HELD: if (svc_done || !HLDA) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
    hrq_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    mask_q    <= mask_d;
    req_eff_q <= req_eff_d;
    state_q   <= state_d;
    hrq_q     <= hrq_d;
  end

  assign req_eff = req_eff_q;
  assign HRQ     = hrq_q;

endmodule
